// File: rtl/game_pkg.sv
// Shared types, widths and helpers for the whack-a-mole game datapath.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam int NUM_HOLES = 4;
    localparam int HOLE_W    = 2;
    localparam int SCORE_W   = 8;
    localparam int LIFE_W    = 4;

    // Number of set bits across the holes; at most NUM_HOLES, so 3 bits suffice.
    function automatic logic [2:0] popcnt4(input logic [NUM_HOLES-1:0] v);
        logic [2:0] sum;
        sum = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            sum = sum + 3'(v[i]);
        end
        return sum;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [2:0]         b);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + {{(SCORE_W-2){1'b0}}, b};
        return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/hole_timer.sv
// One hole: lit flag plus life counter, resolving hit > expire > age > spawn.
// hit_ok / expired are decoded from the pre-cycle state so the top can count
// them in the same update that changes this hole.
module hole_timer
    import game_pkg::*;
#(
    parameter int LIFE_TICKS = 8
) (
    input  logic dclk,
    input  logic rst,
    input  logic clear,
    input  logic spawn,
    input  logic tick,
    input  logic hit,
    output logic active,
    output logic hit_ok,
    output logic expired
);

    localparam logic [LIFE_W-1:0] LIFE_INIT = LIFE_W'(LIFE_TICKS);

    logic [LIFE_W-1:0] life;

    assign hit_ok  = hit & active;
    assign expired = tick & active & ~hit & (life == LIFE_W'(1));

    // Hole state: clear wins, then hit, expiry, aging, and spawn onto a dark hole.
    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            life   <= '0;
        end else if (clear || hit_ok || expired) begin
            active <= 1'b0;
            life   <= '0;
        end else if (tick && active) begin
            life <= life - LIFE_W'(1);
        end else if (spawn && !active) begin
            active <= 1'b1;
            life   <= LIFE_INIT;
        end
    end

endmodule

// File: rtl/mole_spawner.sv
// Game controller: spawns targets from the random hole index on each tick,
// scores hits, counts expired targets and ends the game at MAX_MISS misses.
module mole_spawner
    import game_pkg::*;
#(
    parameter int LIFE_TICKS = 8,
    parameter int MAX_MISS   = 3
) (
    input  logic       dclk,
    input  logic       rst,
    input  logic       start,
    input  logic       tick,
    input  logic [1:0] num,
    input  logic [3:0] hit,
    output logic [3:0] active,
    output logic [7:0] score,
    output logic [7:0] miss_cnt,
    output logic       game_over
);

    localparam logic [SCORE_W-1:0] MISS_LIM = SCORE_W'(MAX_MISS);

    state_t               state, state_nxt;
    logic [SCORE_W-1:0]   score_nxt, miss_nxt;
    logic                 run, go_over, clear;
    logic [NUM_HOLES-1:0] hit_ok, expired;

    // Holes only see tick/hit while a game is running; start overrides both.
    assign run   = (state == RUN) && !start;
    // Holes are held dark outside RUN, on restart, and on the final miss.
    assign clear = (state != RUN) || start || go_over;

    for (genvar i = 0; i < NUM_HOLES; i++) begin : g_hole
        hole_timer #(.LIFE_TICKS(LIFE_TICKS)) u_hole (
            .dclk    (dclk),
            .rst     (rst),
            .clear   (clear),
            .spawn   (run && tick && (num == HOLE_W'(i))),
            .tick    (run && tick),
            .hit     (run && hit[i]),
            .active  (active[i]),
            .hit_ok  (hit_ok[i]),
            .expired (expired[i])
        );
    end

    assign game_over = (state == OVER);

    // Next state and counter values; restart clears both counters.
    always_comb begin
        state_nxt = state;
        score_nxt = score;
        miss_nxt  = miss_cnt;
        go_over   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    score_nxt = '0;
                    miss_nxt  = '0;
                end
            end
            RUN: begin
                if (start) begin
                    score_nxt = '0;
                    miss_nxt  = '0;
                end else begin
                    score_nxt = sat_add(score, popcnt4(hit_ok));
                    miss_nxt  = sat_add(miss_cnt, popcnt4(expired));
                    if (miss_nxt >= MISS_LIM) begin
                        state_nxt = OVER;
                        go_over   = 1'b1;
                    end
                end
            end
            OVER: begin
                if (start) begin
                    state_nxt = RUN;
                    score_nxt = '0;
                    miss_nxt  = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            score    <= '0;
            miss_cnt <= '0;
        end else begin
            state    <= state_nxt;
            score    <= score_nxt;
            miss_cnt <= miss_nxt;
        end
    end

endmodule
